// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: GPR/MDU/eret stall generation, exception flush,
// and the multiply/divide busy countdown FSM with a saturating stall counter.
module pipe_ctrl #(
    parameter int unsigned MULT_CYC = 5,
    parameter int unsigned DIV_CYC  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_data,
    input  logic        md_start,
    input  logic        md_is_div,
    input  logic        md_use_D,
    input  logic        eret_D,
    input  logic        epc_hazard,
    input  logic        Req,
    output logic        f_we,
    output logic        d_we,
    output logic        e_flush,
    output logic        d_flush,
    output logic        req_out,
    output logic        mdu_busy,
    output logic [3:0]  busy_cnt,
    output logic [15:0] stall_cycles
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYC);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt_q;
    logic [3:0]  cnt_next;
    logic [3:0]  load_val;
    logic        md_stall;
    logic        eret_stall;
    logic        stall;
    logic [15:0] stall_cnt_q;

    // State register; mdu_busy is a direct decode of this register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt_q <= 4'd0;
        end else begin
            state <= state_next;
            cnt_q <= cnt_next;
        end
    end

    // Next-state logic. Req cancels a start in the same cycle, but an
    // operation already counting was issued by an older instruction and runs on.
    always_comb begin
        state_next = state;
        cnt_next   = cnt_q;
        load_val   = md_is_div ? DIV_LOAD : MULT_LOAD;
        unique case (state)
            IDLE: begin
                cnt_next = 4'd0;
                if (md_start && !Req && (load_val != 4'd0)) begin
                    state_next = BUSY;
                    cnt_next   = load_val;
                end
            end
            BUSY: begin
                if (cnt_q <= 4'd1) begin
                    state_next = IDLE;
                    cnt_next   = 4'd0;
                end else begin
                    cnt_next = cnt_q - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // Output logic: stall sources are masked by Req so the flush always wins.
    always_comb begin
        mdu_busy   = (state == BUSY);
        busy_cnt   = cnt_q;
        md_stall   = md_use_D & (mdu_busy | md_start);
        eret_stall = eret_D & epc_hazard;
        stall      = (stall_data | md_stall | eret_stall) & ~Req;
        f_we       = ~stall;
        d_we       = ~stall;
        e_flush    = stall;
        d_flush    = eret_D & ~stall & ~Req;
        req_out    = Req;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 16'd0;
        end else if (stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cycles = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: busy countdown scoreboard, stall/flush
// combinational checks, Req dominance, async reset and counter saturation.
module tb_pipe_ctrl;

    logic        clk;
    logic        reset;
    logic        stall_data;
    logic        md_start;
    logic        md_is_div;
    logic        md_use_D;
    logic        eret_D;
    logic        epc_hazard;
    logic        Req;
    logic        f_we;
    logic        d_we;
    logic        e_flush;
    logic        d_flush;
    logic        req_out;
    logic        mdu_busy;
    logic [3:0]  busy_cnt;
    logic [15:0] stall_cycles;

    int tests_run = 0;
    int tests_failed = 0;
    logic [3:0] exp_q[$];
    logic [3:0] exp_cnt;

    pipe_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
        .clk          (clk),
        .reset        (reset),
        .stall_data   (stall_data),
        .md_start     (md_start),
        .md_is_div    (md_is_div),
        .md_use_D     (md_use_D),
        .eret_D       (eret_D),
        .epc_hazard   (epc_hazard),
        .Req          (Req),
        .f_we         (f_we),
        .d_we         (d_we),
        .e_flush      (e_flush),
        .d_flush      (d_flush),
        .req_out      (req_out),
        .mdu_busy     (mdu_busy),
        .busy_cnt     (busy_cnt),
        .stall_cycles (stall_cycles)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic clear_inputs();
        stall_data = 1'b0;
        md_start   = 1'b0;
        md_is_div  = 1'b0;
        md_use_D   = 1'b0;
        eret_D     = 1'b0;
        epc_hazard = 1'b0;
        Req        = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (mdu_busy === 1'b1 && n < 20) begin
            step();
            n++;
        end
        check(tag, {31'd0, mdu_busy}, 32'd0);
    endtask

    initial begin
        clear_inputs();
        reset = 1'b0;
        stall_data = 1'b1;
        #2;
        // Reset state, and comb outputs still live during reset
        check("rst_busy", {31'd0, mdu_busy}, 32'd0);
        check("rst_cnt", {28'd0, busy_cnt}, 32'd0);
        check("rst_stallcnt", {16'd0, stall_cycles}, 32'd0);
        check("rst_fwe_stall", {31'd0, f_we}, 32'd0);
        check("rst_eflush_stall", {31'd0, e_flush}, 32'd1);
        stall_data = 1'b0;
        #1;
        check("rst_fwe", {31'd0, f_we}, 32'd1);
        check("rst_req_out", {31'd0, req_out}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Mult: busy for exactly 5 cycles
        md_start = 1'b1;
        md_is_div = 1'b0;
        #1;
        check("mult_issue_busy", {31'd0, mdu_busy}, 32'd0);
        check("mult_issue_fwe", {31'd0, f_we}, 32'd1);
        for (int i = 5; i >= 0; i--) exp_q.push_back(4'(i));
        step();
        md_start = 1'b0;
        while (exp_q.size() > 0) begin
            exp_cnt = exp_q.pop_front();
            check("mult_cnt", {28'd0, busy_cnt}, {28'd0, exp_cnt});
            check("mult_busy", {31'd0, mdu_busy}, {31'd0, (exp_cnt != 4'd0)});
            if (exp_q.size() > 0) step();
        end

        // Div with a dependent mult/div user held in D
        md_start = 1'b1;
        md_is_div = 1'b1;
        step();
        md_start = 1'b0;
        md_is_div = 1'b0;
        md_use_D = 1'b1;
        for (int i = 10; i >= 1; i--) exp_q.push_back(4'(i));
        #1;
        while (exp_q.size() > 0) begin
            exp_cnt = exp_q.pop_front();
            check("div_cnt", {28'd0, busy_cnt}, {28'd0, exp_cnt});
            check("div_fwe", {31'd0, f_we}, 32'd0);
            check("div_dwe", {31'd0, d_we}, 32'd0);
            check("div_eflush", {31'd0, e_flush}, 32'd1);
            step();
        end
        check("div_idle", {31'd0, mdu_busy}, 32'd0);
        check("div_release_fwe", {31'd0, f_we}, 32'd1);
        md_use_D = 1'b0;
        check("div_stallcnt", {16'd0, stall_cycles}, 32'd10);

        // md_start and md_use_D together
        md_start = 1'b1;
        md_use_D = 1'b1;
        #1;
        check("same_stall_fwe", {31'd0, f_we}, 32'd0);
        check("same_stall_eflush", {31'd0, e_flush}, 32'd1);
        step();
        md_start = 1'b0;
        md_use_D = 1'b0;
        check("same_busy", {31'd0, mdu_busy}, 32'd1);
        check("same_cnt", {28'd0, busy_cnt}, 32'd5);
        check("same_stallcnt", {16'd0, stall_cycles}, 32'd11);
        wait_idle("same_idle");

        // Req cancels a start and dominates every stall source
        md_start = 1'b1;
        md_use_D = 1'b1;
        stall_data = 1'b1;
        eret_D = 1'b1;
        epc_hazard = 1'b1;
        Req = 1'b1;
        #1;
        check("req_out", {31'd0, req_out}, 32'd1);
        check("req_fwe", {31'd0, f_we}, 32'd1);
        check("req_dwe", {31'd0, d_we}, 32'd1);
        check("req_eflush", {31'd0, e_flush}, 32'd0);
        check("req_dflush", {31'd0, d_flush}, 32'd0);
        step();
        check("req_idle", {31'd0, mdu_busy}, 32'd0);
        check("req_cnt", {28'd0, busy_cnt}, 32'd0);
        check("req_stallcnt", {16'd0, stall_cycles}, 32'd11);
        clear_inputs();

        // eret behind an EPC write, then release
        eret_D = 1'b1;
        epc_hazard = 1'b1;
        #1;
        check("eret_fwe", {31'd0, f_we}, 32'd0);
        check("eret_dflush_hold", {31'd0, d_flush}, 32'd0);
        step();
        epc_hazard = 1'b0;
        #1;
        check("eret_dflush", {31'd0, d_flush}, 32'd1);
        check("eret_fwe_go", {31'd0, f_we}, 32'd1);
        step();
        eret_D = 1'b0;
        check("eret_stallcnt", {16'd0, stall_cycles}, 32'd12);

        // Req during BUSY leaves the countdown alone
        md_start = 1'b1;
        step();
        md_start = 1'b0;
        Req = 1'b1;
        check("reqbusy_cnt5", {28'd0, busy_cnt}, 32'd5);
        step();
        check("reqbusy_cnt4", {28'd0, busy_cnt}, 32'd4);
        check("reqbusy_busy", {31'd0, mdu_busy}, 32'd1);
        Req = 1'b0;
        wait_idle("reqbusy_idle");

        // Asynchronous reset mid-div at busy_cnt=6
        md_start = 1'b1;
        md_is_div = 1'b1;
        step();
        md_start = 1'b0;
        md_is_div = 1'b0;
        repeat (4) step();
        check("arst_pre_cnt", {28'd0, busy_cnt}, 32'd6);
        #1;
        reset = 1'b0;
        #1;
        check("arst_cnt", {28'd0, busy_cnt}, 32'd0);
        check("arst_busy", {31'd0, mdu_busy}, 32'd0);
        check("arst_stallcnt", {16'd0, stall_cycles}, 32'd0);
        #1;
        reset = 1'b1;
        step();
        check("arst_resume", {31'd0, mdu_busy}, 32'd0);

        // Stall counter saturation
        stall_data = 1'b1;
        repeat (65534) step();
        check("sat_fffe", {16'd0, stall_cycles}, 32'h0000FFFE);
        step();
        check("sat_ffff", {16'd0, stall_cycles}, 32'h0000FFFF);
        repeat (2) step();
        check("sat_hold", {16'd0, stall_cycles}, 32'h0000FFFF);
        stall_data = 1'b0;

        // Final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
